matmul_tile_sequencer: RTL and testbench

MATMUL_TILE_SEQUENCER -- requirements
Module: matmul_tile_sequencer

---
 rtl/matmul_tile_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_matmul_tile_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_tile_sequencer
//
// Walks an output matrix tile by tile for an N x N systolic core. For every
// output tile (r, c) it streams K_STEPS beats of input-row / weight-column
// reads out of two block RAMs, marks the first and last beat for the core,
// waits for the core to report the tile result, and then issues one write of
// that tile to the output RAM. Tiles are visited row-major: c runs fastest.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   en           global advance enable; low freezes every register and
//                masks the strobes (in_en, wb_en, out_we, core_valid, done)
//   clr          synchronous abort back to IDLE, beats en and start
//   start        begin a job (only looked at in IDLE with en high)
//   cfg_i_tiles  row-tile count, latched when start is accepted
//   cfg_w_tiles  column-tile count, latched when start is accepted
//   ready        high while idle
//   done         one-cycle pulse when a job completes
//   in_en/in_addr    input RAM read strobe / address   (r*K_STEPS + k)
//   wb_en/wb_addr    weight RAM read strobe / address  (c*K_STEPS + k)
//   core_valid   read data valid at the core (read strobe delayed one beat)
//   core_first   qualifies the k = 0 beat
//   core_last    qualifies the k = K_STEPS-1 beat
//   core_done    core result for the current tile is ready (used in WAIT)
//   out_we/out_addr  output RAM write strobe / tile address (r*w_tiles + c)
// -----------------------------------------------------------------------------
module matmul_tile_sequencer #(
  parameter int BLOCK_SIZE      = 2,
  parameter int INNER_DIMENSION = 256,
  parameter int MAX_I_TILES     = 1377,
  parameter int MAX_W_TILES     = 32,
  // Derived sizes; the guards keep every width at least one bit.
  localparam int K_STEPS = INNER_DIMENSION / BLOCK_SIZE,
  localparam int KW = (K_STEPS > 1) ? $clog2(K_STEPS) : 1,
  localparam int IW = (MAX_I_TILES > 0) ? $clog2(MAX_I_TILES + 1) : 1,
  localparam int WW = (MAX_W_TILES > 0) ? $clog2(MAX_W_TILES + 1) : 1,
  localparam int IA = (MAX_I_TILES * K_STEPS > 1) ? $clog2(MAX_I_TILES * K_STEPS) : 1,
  localparam int WA = (MAX_W_TILES * K_STEPS > 1) ? $clog2(MAX_W_TILES * K_STEPS) : 1,
  localparam int OA = (MAX_I_TILES * MAX_W_TILES > 1) ? $clog2(MAX_I_TILES * MAX_W_TILES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          start,
  input  logic [IW-1:0] cfg_i_tiles,
  input  logic [WW-1:0] cfg_w_tiles,
  output logic          ready,
  output logic          done,
  output logic          in_en,
  output logic [IA-1:0] in_addr,
  output logic          wb_en,
  output logic [WA-1:0] wb_addr,
  output logic          core_valid,
  output logic          core_first,
  output logic          core_last,
  input  logic          core_done,
  output logic          out_we,
  output logic [OA-1:0] out_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] r_reg, r_next;          // current row tile
  logic [WW-1:0] c_reg, c_next;          // current column tile
  logic [KW-1:0] k_reg, k_next;          // beat within the tile
  logic [IW-1:0] cfg_i_reg, cfg_i_next;  // latched job size
  logic [WW-1:0] cfg_w_reg, cfg_w_next;

  // Read-latency pipeline: the RAM returns data one enabled cycle after the
  // strobe, so the core qualifiers are the strobe qualifiers delayed once.
  logic cv_reg, cv_next;
  logic cf_reg, cf_next;
  logic cl_reg, cl_next;

  // Job size clamped to what the address space was sized for.
  logic [IW-1:0] cfg_i_sat;
  logic [WW-1:0] cfg_w_sat;

  logic last_k;
  logic last_c;
  logic last_r;

  always_comb begin
    cfg_i_sat = (cfg_i_tiles > IW'(MAX_I_TILES)) ? IW'(MAX_I_TILES) : cfg_i_tiles;
    cfg_w_sat = (cfg_w_tiles > WW'(MAX_W_TILES)) ? WW'(MAX_W_TILES) : cfg_w_tiles;
  end

  // The latched counts are never zero outside IDLE/FIN, so the minus-one
  // comparisons below cannot wrap while they matter.
  assign last_k = (k_reg == KW'(K_STEPS - 1));
  assign last_c = (c_reg == (cfg_w_reg - WW'(1)));
  assign last_r = (r_reg == (cfg_i_reg - IW'(1)));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      r_reg     <= '0;
      c_reg     <= '0;
      k_reg     <= '0;
      cfg_i_reg <= '0;
      cfg_w_reg <= '0;
      cv_reg    <= 1'b0;
      cf_reg    <= 1'b0;
      cl_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      c_reg     <= c_next;
      k_reg     <= k_next;
      cfg_i_reg <= cfg_i_next;
      cfg_w_reg <= cfg_w_next;
      cv_reg    <= cv_next;
      cf_reg    <= cf_next;
      cl_reg    <= cl_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Nothing moves unless en is high; clr overrides all.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    c_next     = c_reg;
    k_next     = k_reg;
    cfg_i_next = cfg_i_reg;
    cfg_w_next = cfg_w_reg;
    cv_next    = cv_reg;
    cf_next    = cf_reg;
    cl_next    = cl_reg;

    if (clr) begin
      state_next = S_IDLE;
      r_next     = '0;
      c_next     = '0;
      k_next     = '0;
      cv_next    = 1'b0;
      cf_next    = 1'b0;
      cl_next    = 1'b0;
    end else if (en) begin
      // Delay the read strobe and its beat markers by one enabled cycle.
      cv_next = (state_reg == S_FEED);
      cf_next = (state_reg == S_FEED) && (k_reg == '0);
      cl_next = (state_reg == S_FEED) && last_k;

      unique case (state_reg)
        S_IDLE: begin
          if (start) begin
            cfg_i_next = cfg_i_sat;
            cfg_w_next = cfg_w_sat;
            r_next     = '0;
            c_next     = '0;
            k_next     = '0;
            if ((cfg_i_sat == '0) || (cfg_w_sat == '0)) begin
              state_next = S_FIN;
            end else begin
              state_next = S_FEED;
            end
          end
        end

        S_FEED: begin
          if (last_k) begin
            k_next     = '0;
            state_next = S_DRAIN;
          end else begin
            k_next = k_reg + KW'(1);
          end
        end

        // The last read's data reaches the core during this cycle.
        S_DRAIN: begin
          state_next = S_WAIT;
        end

        S_WAIT: begin
          if (core_done) begin
            state_next = S_WRITE;
          end
        end

        S_WRITE: begin
          if (last_c) begin
            c_next = '0;
            if (last_r) begin
              r_next     = '0;
              state_next = S_FIN;
            end else begin
              r_next     = r_reg + IW'(1);
              state_next = S_FEED;
            end
          end else begin
            c_next     = c_reg + WW'(1);
            state_next = S_FEED;
          end
        end

        S_FIN: begin
          state_next = S_IDLE;
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Strobes are masked by en so a frozen cycle never issues a read,
  // write or completion that the (also frozen) counters would then repeat.
  // ---------------------------------------------------------------------------
  assign ready      = (state_reg == S_IDLE);
  assign done       = (state_reg == S_FIN) && en;
  assign in_en      = (state_reg == S_FEED) && en;
  assign wb_en      = (state_reg == S_FEED) && en;
  assign out_we     = (state_reg == S_WRITE) && en;
  assign core_valid = cv_reg && en;
  assign core_first = cf_reg && en;
  assign core_last  = cl_reg && en;

  // Addresses are formed at their full output width; every in-range tile
  // index produces a value that fits, so no bits are lost.
  assign in_addr  = (IA'(r_reg) * IA'(K_STEPS)) + IA'(k_reg);
  assign wb_addr  = (WA'(c_reg) * WA'(K_STEPS)) + WA'(k_reg);
  assign out_addr = (OA'(r_reg) * OA'(cfg_w_reg)) + OA'(c_reg);

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_tile_sequencer
//
// Scoreboard bench: each job pushes its expected read beats, core qualifiers,
// output writes and done pulse into queues; a per-cycle monitor (sampling on
// the falling edge) pops and compares whenever the sequencer produces them.
// A small responder raises core_done three cycles after the last core beat.
// -----------------------------------------------------------------------------
module tb_matmul_tile_sequencer;

  localparam int BS = 2;
  localparam int ID = 8;
  localparam int MI = 2;
  localparam int MW = 5;
  localparam int K  = ID / BS;
  localparam int IW = $clog2(MI + 1);
  localparam int WW = $clog2(MW + 1);
  localparam int IA = $clog2(MI * K);
  localparam int WA = $clog2(MW * K);
  localparam int OA = $clog2(MI * MW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] cfg_i_tiles = '0;
  logic [WW-1:0] cfg_w_tiles = '0;
  logic          core_done = 1'b0;
  logic          ready, done, in_en, wb_en, out_we;
  logic          core_valid, core_first, core_last;
  logic [IA-1:0] in_addr;
  logic [WA-1:0] wb_addr;
  logic [OA-1:0] out_addr;

  matmul_tile_sequencer #(
    .BLOCK_SIZE(BS),
    .INNER_DIMENSION(ID),
    .MAX_I_TILES(MI),
    .MAX_W_TILES(MW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .clr(clr),
    .start(start),
    .cfg_i_tiles(cfg_i_tiles),
    .cfg_w_tiles(cfg_w_tiles),
    .ready(ready),
    .done(done),
    .in_en(in_en),
    .in_addr(in_addr),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .core_valid(core_valid),
    .core_first(core_first),
    .core_last(core_last),
    .core_done(core_done),
    .out_we(out_we),
    .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  int in_q[$];
  int wb_q[$];
  int core_q[$];
  int wr_q[$];
  int done_q[$];
  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int done_cnt = 0;
  int last_cnt = 0;
  int wr_cnt = 0;
  bit auto_core = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Falling-edge sampling of every DUT output against the scoreboard queues.
  task automatic monitor();
    int e;
    if (!rst_n) begin
      resp_cnt  = 0;
      core_done = 1'b0;
      return;
    end
    if (in_en || wb_en) begin
      check_val("wb_en_vs_in_en", wb_en, in_en);
      if (in_q.size() == 0) begin
        check_val("rd_unexpected", 1, 0);
      end else begin
        e = in_q.pop_front();
        check_val("in_addr", in_addr, e);
        e = wb_q.pop_front();
        check_val("wb_addr", wb_addr, e);
        $display("rd  in_addr=%0d wb_addr=%0d", in_addr, wb_addr);
      end
    end
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) core_done = 1'b1;
    end
    if (core_valid) begin
      if (core_q.size() == 0) begin
        check_val("core_unexpected", 1, 0);
      end else begin
        e = core_q.pop_front();
        check_val("core_first_last", {core_first, core_last}, e);
      end
      if (core_last) begin
        last_cnt++;
        if (auto_core) resp_cnt = 3;
      end
    end else if (core_first || core_last) begin
      check_val("core_qual_no_valid", {core_first, core_last}, 0);
    end
    if (out_we) begin
      wr_cnt++;
      core_done = 1'b0;
      if (wr_q.size() == 0) begin
        check_val("wr_unexpected", 1, 0);
      end else begin
        e = wr_q.pop_front();
        check_val("out_addr", out_addr, e);
        $display("wr  out_addr=%0d", out_addr);
      end
    end
    if (done) begin
      done_cnt++;
      $display("done pulse");
      if (done_q.size() == 0) check_val("done_unexpected", 1, 0);
      else void'(done_q.pop_front());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input int ni, input int nw, input bit full);
    for (int r = 0; r < ni; r++) begin
      for (int c = 0; c < nw; c++) begin
        for (int k = 0; k < K; k++) begin
          in_q.push_back(r * K + k);
          wb_q.push_back(c * K + k);
          core_q.push_back(((k == 0) ? 2 : 0) + ((k == K - 1) ? 1 : 0));
        end
        if (full) wr_q.push_back(r * nw + c);
      end
    end
    if (full) done_q.push_back(1);
  endtask

  // Start is held for 'hold' extra cycles after acceptance, with different
  // cfg values, to show the running job ignores both.
  task automatic start_job(input int ci, input int cw, input int hold);
    cfg_i_tiles = IW'(ci);
    cfg_w_tiles = WW'(cw);
    start = 1'b1;
    tick();
    cfg_i_tiles = IW'(1);
    cfg_w_tiles = WW'(3);
    repeat (hold) tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    check_val({tag, "_done_seen"}, (done_cnt != base), 1);
    check_val({tag, "_ready_after"}, ready, 1);
  endtask

  task automatic check_empty(input string tag);
    check_val(tag, in_q.size() + wb_q.size() + core_q.size() + wr_q.size() + done_q.size(), 0);
  endtask

  initial begin
    int n;
    int base;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", ready, 1);
    check_val("rst_done", done, 0);
    check_val("rst_strobes", {in_en, wb_en, out_we, core_valid}, 0);
    check_val("rst_addr", {in_addr, wb_addr, out_addr}, 0);
    rst_n = 1'b1;
    tick();

    // 1x1 job
    push_job(1, 1, 1);
    start_job(1, 1, 2);
    wait_done("j1x1", 200);
    check_empty("j1x1_queues");

    // 2x3 job
    push_job(2, 3, 1);
    start_job(2, 3, 2);
    wait_done("j2x3", 400);
    check_empty("j2x3_queues");

    // zero row tiles: straight to FIN
    push_job(0, 2, 1);
    base = wr_cnt;
    start_job(0, 2, 0);
    check_val("zero_done_in_fin", done, 1);
    check_val("zero_not_ready", ready, 0);
    wait_done("zero", 10);
    check_val("zero_no_write", wr_cnt - base, 0);
    check_empty("zero_queues");

    // en low for two cycles at k=2
    push_job(1, 1, 1);
    start_job(1, 1, 0);
    n = 0;
    while (!(in_en && in_addr == IA'(2)) && n < 20) begin
      tick();
      n++;
    end
    check_val("enlow_reached_k2", (in_en && in_addr == IA'(2)), 1);
    en = 1'b0;
    #1;
    check_val("enlow_in_en", {in_en, wb_en, core_valid}, 0);
    check_val("enlow_addr_hold", in_addr, 2);
    tick();
    check_val("enlow_addr_hold2", {in_addr, wb_addr}, {IA'(2), WA'(2)});
    check_val("enlow_strobes2", {in_en, wb_en, core_valid, out_we, done}, 0);
    tick();
    en = 1'b1;
    wait_done("enlow", 200);
    check_empty("enlow_queues");

    // clr while waiting on the core
    auto_core = 1'b0;
    push_job(1, 1, 0);
    base = last_cnt;
    start_job(1, 1, 0);
    n = 0;
    while (last_cnt == base && n < 30) begin
      tick();
      n++;
    end
    check_val("clr_last_seen", (last_cnt != base), 1);
    tick();
    tick();
    check_val("clr_busy_before", ready, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("clr_ready", ready, 1);
    check_val("clr_strobes", {out_we, done, in_en, core_valid}, 0);
    base = done_cnt;
    n = wr_cnt;
    repeat (4) tick();
    check_val("clr_no_done", done_cnt - base, 0);
    check_val("clr_no_write", wr_cnt - n, 0);
    check_empty("clr_queues");
    auto_core = 1'b1;
    push_job(1, 1, 1);
    start_job(1, 1, 0);
    wait_done("after_clr", 200);
    check_empty("after_clr_queues");

    // asynchronous reset during FEED
    push_job(2, 2, 0);
    start_job(2, 2, 0);
    n = 0;
    while (!(in_en && in_addr == IA'(1)) && n < 20) begin
      tick();
      n++;
    end
    check_val("arst_reached_k1", (in_en && in_addr == IA'(1)), 1);
    rst_n = 1'b0;
    #1;
    check_val("arst_ready", ready, 1);
    check_val("arst_strobes", {in_en, wb_en, out_we, core_valid, core_first, core_last, done}, 0);
    check_val("arst_addr", {in_addr, wb_addr, out_addr}, 0);
    in_q.delete();
    wb_q.delete();
    core_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_val("arst_ready_after", ready, 1);
    check_empty("arst_queues");

    // oversize cfg saturates to 2 x 5; start pulses while busy are ignored
    push_job(MI, MW, 1);
    start_job(3, 6, 2);
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("sat", 2000);
    check_empty("sat_queues");
    repeat (3) tick();
    check_val("final_idle", {ready, done, in_en, out_we}, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
